load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles in REQ without ack before fault (range 1-65535).
REQ-002 SHALL have clk_w_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_w_i_h  in  1  reset, synchronous, active-high.
REQ-004 SHALL have start_w_i_h  in  1  access request strobe, sampled only in IDLE.
REQ-005 SHALL have we_w_i_h  in  1  1=store, 0=load.
REQ-006 SHALL have funct3_w_i  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have addr_w_i  in  32  effective address, taken from the ALU result.
REQ-008 SHALL have wdata_w_i  in  32  store data (rs2).
REQ-009 SHALL have mem_ack_w_i_h  in  1  memory completion; mem_rdata_w_i  in  32  read word, valid with ack.
REQ-010 SHALL have mem_req_w_o_h, mem_we_w_o_h  out  1 each; mem_addr_w_o  out  32; mem_wdata_w_o  out  32; mem_be_w_o  out  4.
REQ-011 SHALL have busy_w_o_h  out  1; done_w_o_h  out  1; rdata_w_o  out  32; misalign_w_o_h  out  1; fault_w_o_h  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, RESP; busy_w_o_h=1 whenever state is not IDLE.
REQ-013 IDLE + start_w_i_h=1: SHALL latch we, funct3, addr, wdata. If the access is legal, next state is REQ; otherwise next state is RESP with misalign flagged.
REQ-014 Illegal access SHALL be any of: H/HU with addr[0]=1; W with addr[1:0]!=00; funct3 in {011,110,111}; store with funct3 100 or 101.
REQ-015 In REQ, mem_req_w_o_h SHALL be 1, and mem_we/addr/wdata/be SHALL hold stable until the cycle in which mem_ack_w_i_h=1.
REQ-016 mem_addr_w_o SHALL be {addr[31:2],2'b00}.
REQ-017 mem_be_w_o SHALL be 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, and 1111 for W, for both loads and stores.
REQ-018 mem_wdata_w_o SHALL carry the byte replicated to 4 lanes for SB, the halfword replicated to 2 lanes for SH, and the full word for SW.
REQ-019 REQ + ack: on a load, SHALL shift mem_rdata_w_i right by 8*addr[1:0], then sign-extend (B,H) or zero-extend (BU,HU) into rdata_w_o; next state RESP.
REQ-020 On a store, rdata_w_o SHALL be left unchanged.
REQ-021 A 16-bit timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-022 When the timeout counter reaches TIMEOUT_CYCLES without ack, SHALL drop mem_req and go to RESP with fault flagged.
REQ-023 On timeout, rdata_w_o SHALL be left unchanged.
REQ-024 An ack in the same cycle as the timeout terminal count SHALL take priority; no fault is raised.
REQ-025 RESP SHALL pulse done_w_o_h for exactly one cycle, with misalign_w_o_h/fault_w_o_h valid that cycle only, then return to IDLE.
REQ-026 Latency: start at cycle N with ack at cycle N+1 SHALL give done at N+2; illegal start at N SHALL give done at N+1 with no mem_req.
REQ-027 start_w_i_h while busy SHALL be ignored, with no queuing.
REQ-028 mem_ack_w_i_h outside REQ SHALL be ignored.
REQ-029 rdata_w_o SHALL hold its value until the next completed load.

Reset
REQ-030 rst_w_i_h=1 at a rising edge SHALL force IDLE in any state, including mid-REQ.
REQ-031 Reset SHALL clear the timeout counter and all latched operands.
REQ-032 After reset, every output SHALL be 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, rdata, misalign, fault.
REQ-033 Reset SHALL take priority over start and ack in the same cycle.

Verification
REQ-034 LB addr=0x1003, mem_rdata=0x80FF_1234, ack 1 cycle after req -> mem_addr=0x1000, be=1000, rdata=0xFFFF_FF80, done at N+2.
REQ-035 LHU addr=0x2002, rdata word 0x9ABC_0000 -> be=1100, rdata=0x0000_9ABC. SH addr=0x2002, wdata=0x1234_5678 -> mem_wdata=0x5678_5678, be=1100, we=1.
REQ-036 LW addr=0x3001 -> done at N+1 with misalign=1, mem_req never asserted. SB with funct3=100 -> misalign=1.
REQ-037 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done with fault=1 and rdata unchanged. A second run with ack on cycle 4 -> fault=0.
REQ-038 Reset asserted during REQ (ack withheld) -> next cycle all outputs 0, state IDLE. A new SW addr=0x40 then completes normally with be=1111.
REQ-039 start pulsed every cycle during a 3-cycle-wait load -> exactly one mem_req transaction and one done pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one memory access at a time, with misalignment
// screening, lane steering/extension and a request timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_w_i,
    input  logic        rst_w_i_h,
    input  logic        start_w_i_h,
    input  logic        we_w_i_h,
    input  logic [2:0]  funct3_w_i,
    input  logic [31:0] addr_w_i,
    input  logic [31:0] wdata_w_i,
    input  logic        mem_ack_w_i_h,
    input  logic [31:0] mem_rdata_w_i,
    output logic        mem_req_w_o_h,
    output logic        mem_we_w_o_h,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_wdata_w_o,
    output logic [3:0]  mem_be_w_o,
    output logic        busy_w_o_h,
    output logic        done_w_o_h,
    output logic [31:0] rdata_w_o,
    output logic        misalign_w_o_h,
    output logic        fault_w_o_h
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    // Counter value in the last REQ cycle allowed before the fault fires.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;

    logic        illegal;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        illegal = 1'b0;
        case (funct3_w_i)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = addr_w_i[0];
            3'b010:         illegal = (addr_w_i[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
        if (we_w_i_h && funct3_w_i[2])
            illegal = 1'b1;
    end

    always_comb begin
        shifted  = mem_rdata_w_i >> {op_q.addr[1:0], 3'b000};
        load_val = shifted;
        case (op_q.funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                misalign_d = 1'b0;
                fault_d    = 1'b0;
                if (start_w_i_h) begin
                    op_d = '{we: we_w_i_h, funct3: funct3_w_i,
                             addr: addr_w_i, wdata: wdata_w_i};
                    tmo_d = 16'd0;
                    if (illegal) begin
                        misalign_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Ack wins over the terminal count in the same cycle.
                if (mem_ack_w_i_h) begin
                    if (!op_q.we)
                        rdata_d = load_val;
                    state_d = S_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_w_i) begin
        if (rst_w_i_h) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            tmo_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    // Memory-side outputs are driven only while a request is outstanding.
    always_comb begin
        mem_req_w_o_h = (state_q == S_REQ);
        mem_we_w_o_h  = 1'b0;
        mem_addr_w_o  = '0;
        mem_wdata_w_o = '0;
        mem_be_w_o    = '0;
        if (state_q == S_REQ) begin
            mem_we_w_o_h = op_q.we;
            mem_addr_w_o = {op_q.addr[31:2], 2'b00};
            case (op_q.funct3[1:0])
                2'b00: begin
                    mem_be_w_o    = 4'b0001 << op_q.addr[1:0];
                    mem_wdata_w_o = {4{op_q.wdata[7:0]}};
                end
                2'b01: begin
                    mem_be_w_o    = 4'b0011 << op_q.addr[1:0];
                    mem_wdata_w_o = {2{op_q.wdata[15:0]}};
                end
                default: begin
                    mem_be_w_o    = 4'b1111;
                    mem_wdata_w_o = op_q.wdata;
                end
            endcase
        end
    end

    assign busy_w_o_h     = (state_q != S_IDLE);
    assign done_w_o_h     = (state_q == S_RESP);
    assign rdata_w_o      = rdata_q;
    assign misalign_w_o_h = (state_q == S_RESP) && misalign_q;
    assign fault_w_o_h    = (state_q == S_RESP) && fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, start, we, ack;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, mrdata;
    logic        mreq, mwe, busy, done, mis, flt;
    logic [31:0] maddr, mwdata, rdata;
    logic [3:0]  mbe;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_w_i(clk), .rst_w_i_h(rst), .start_w_i_h(start), .we_w_i_h(we),
        .funct3_w_i(f3), .addr_w_i(addr), .wdata_w_i(wdata),
        .mem_ack_w_i_h(ack), .mem_rdata_w_i(mrdata),
        .mem_req_w_o_h(mreq), .mem_we_w_o_h(mwe), .mem_addr_w_o(maddr),
        .mem_wdata_w_o(mwdata), .mem_be_w_o(mbe), .busy_w_o_h(busy),
        .done_w_o_h(done), .rdata_w_o(rdata), .misalign_w_o_h(mis),
        .fault_w_o_h(flt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero"}, {28'd0, mreq, mwe, busy, done} | maddr | mwdata | rdata
            | {28'd0, mbe} | {30'd0, mis, flt}, 32'd0);
    endtask

    int req_txn, done_cnt;
    logic prev_req;

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; ack = 1'b0;
        f3 = '0; addr = '0; wdata = '0; mrdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // LB 0x1003, ack one cycle after request
        go(1'b0, 3'b000, 32'h1003, 32'h0);
        chk("lb_req", {31'd0, mreq}, 32'd1);
        chk("lb_addr", maddr, 32'h1000);
        chk("lb_be", {28'd0, mbe}, 32'h8);
        ack = 1'b1; mrdata = 32'h80FF_1234;
        chk("lb_nodone_n1", {31'd0, done}, 32'd0);
        tick();
        ack = 1'b0;
        chk("lb_done_n2", {31'd0, done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_flags", {30'd0, mis, flt}, 32'd0);
        tick();
        chk("lb_idle", {30'd0, busy, done}, 32'd0);

        // LHU 0x2002
        go(1'b0, 3'b101, 32'h2002, 32'h0);
        chk("lhu_be", {28'd0, mbe}, 32'hC);
        ack = 1'b1; mrdata = 32'h9ABC_0000;
        tick(); ack = 1'b0;
        chk("lhu_rdata", rdata, 32'h0000_9ABC);
        tick();

        // SH 0x2002
        go(1'b1, 3'b001, 32'h2002, 32'h1234_5678);
        chk("sh_wdata", mwdata, 32'h5678_5678);
        chk("sh_be", {28'd0, mbe}, 32'hC);
        chk("sh_we", {31'd0, mwe}, 32'd1);
        ack = 1'b1; mrdata = 32'hFFFF_FFFF;
        tick(); ack = 1'b0;
        chk("sh_done", {31'd0, done}, 32'd1);
        chk("sh_rdata_kept", rdata, 32'h0000_9ABC);
        tick();

        // LW misaligned: done at N+1, no request
        go(1'b0, 3'b010, 32'h3001, 32'h0);
        chk("lw_mis_done", {29'd0, mreq, done, mis}, 32'b011);
        tick();
        chk("lw_mis_clear", {29'd0, busy, done, mis}, 32'd0);

        // SB encoded with funct3=100 is illegal
        go(1'b1, 3'b100, 32'h3000, 32'h0);
        chk("sbu_mis", {29'd0, mreq, done, mis}, 32'b011);
        tick();

        // Timeout: 4 request cycles, then fault
        go(1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_req_c%0d", i + 1), {30'd0, mreq, done}, 32'b10);
            tick();
        end
        chk("tmo_fault", {28'd0, mreq, done, mis, flt}, 32'b0101);
        chk("tmo_rdata_kept", rdata, 32'h0000_9ABC);
        tick();

        // Ack on the terminal cycle wins
        go(1'b0, 3'b010, 32'h10, 32'h0);
        tick(); tick(); tick();
        ack = 1'b1; mrdata = 32'hCAFE_BABE;
        chk("tmo_ack_c4_req", {31'd0, mreq}, 32'd1);
        tick(); ack = 1'b0;
        chk("tmo_ack_nofault", {30'd0, done, flt}, 32'b10);
        chk("tmo_ack_rdata", rdata, 32'hCAFE_BABE);
        tick();

        // Reset mid-request, also racing a start
        go(1'b0, 3'b000, 32'h5, 32'h0);
        chk("rst_pre_req", {31'd0, mreq}, 32'd1);
        rst = 1'b1; start = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        chk_all_zero("rst_midreq");
        tick();
        chk("rst_stays_idle", {31'd0, busy}, 32'd0);

        // SW after reset
        go(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        chk("sw_be", {28'd0, mbe}, 32'hF);
        chk("sw_wdata", mwdata, 32'hDEAD_BEEF);
        chk("sw_addr", maddr, 32'h40);
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("sw_done", {31'd0, done}, 32'd1);
        tick();

        // Start held high during a load that waits 3 cycles
        req_txn = 0; done_cnt = 0; prev_req = 1'b0;
        we = 1'b0; f3 = 3'b100; addr = 32'h51; mrdata = 32'h0000_AB00;
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            ack = mreq && dut.tmo_q == 16'd2;
            if (done) start = 1'b0;
            if (mreq && !prev_req) req_txn++;
            if (done) done_cnt++;
            prev_req = mreq;
            tick();
        end
        start = 1'b0; ack = 1'b0;
        chk("spam_req_txn", req_txn, 32'd1);
        chk("spam_done", done_cnt, 32'd1);
        chk("spam_rdata", rdata, 32'h0000_00AB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
